// File: rtl/addsub_acc_pkg.sv
// Shared types and constants for the add/sub accumulator stage.
package addsub_acc_pkg;

  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLR = 2'b11} acc_op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_EXEC = 2'b01, S_RESP = 2'b10} acc_state_e;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/addsub_32_bits.sv
// Ripple-carry adder/subtractor; i_add_sub=1 computes i_a - i_b.
// o_ovf is the signed overflow (carry into MSB xor carry out of MSB).
module addsub_32_bits #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_add_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_ovf
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_b;

  // Subtract as a + ~b + 1: invert b and feed the carry-in.
  assign w_b    = i_b ^ {WIDTH{i_add_sub}};
  assign w_c[0] = i_add_sub;

  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    assign o_sum[g]   = i_a[g] ^ w_b[g] ^ w_c[g];
    assign w_c[g+1]   = (i_a[g] & w_b[g]) | (w_c[g] & (i_a[g] ^ w_b[g]));
  end

  assign o_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule

// File: rtl/addsub_acc_32b.sv
// Accumulator stage: one command per handshake (LOAD/ADD/SUB/CLR), optional
// signed saturation, sticky overflow, result returned on a valid/ready channel.
module addsub_acc_32b
  import addsub_acc_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_out,
  output logic             ovf,
  output logic             ovf_sticky,
  output logic             zero,
  output logic             neg
);

  acc_state_e       r_state;
  acc_op_e          r_op;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf, r_sticky, r_zero, r_neg;
  logic             r_in_ready, r_out_valid;

  logic [WIDTH-1:0] w_sum, w_sat, w_acc_nxt;
  logic             w_v, w_arith;

  addsub_32_bits #(.WIDTH(WIDTH)) u_addsub (
    .i_a       (r_acc),
    .i_b       (r_operand),
    .i_add_sub (r_op == OP_SUB),
    .o_sum     (w_sum),
    .o_ovf     (w_v)
  );

  // On overflow the true result lies beyond the rail on the accumulator's side.
  assign w_sat   = r_acc[WIDTH-1] ? WIDTH'(SAT_NEG) : WIDTH'(SAT_POS);
  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

  always_comb begin
    w_acc_nxt = w_sum;
    case (r_op)
      OP_LOAD: w_acc_nxt = r_operand;
      OP_CLR:  w_acc_nxt = '0;
      default: w_acc_nxt = (w_v && (SATURATE != 0)) ? w_sat : w_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_LOAD;
      r_operand   <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_sticky    <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op       <= acc_op_e'(op);
          r_operand  <= operand;
          r_in_ready <= 1'b0;
          r_state    <= S_EXEC;
        end
        S_EXEC: begin
          r_acc       <= w_acc_nxt;
          r_zero      <= (w_acc_nxt == '0);
          r_neg       <= w_acc_nxt[WIDTH-1];
          r_ovf       <= w_arith & w_v;
          r_sticky    <= (r_op == OP_CLR) ? 1'b0 : (r_sticky | (w_arith & w_v));
          r_out_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign acc_out    = r_acc;
  assign ovf        = r_ovf;
  assign ovf_sticky = r_sticky;
  assign zero       = r_zero;
  assign neg        = r_neg;

endmodule
